// File: rtl/fifo_stream_drain.sv
// Drains a registered-output FIFO read port into a valid/ready stream.
// Captured words go through a 2-entry skid buffer so back-pressure never drops or repeats a word.
module fifo_stream_drain #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       buf_count
);

    logic             q_fresh_reg;
    logic [1:0]       arm_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] head_next;
    logic [WIDTH-1:0] tail_reg;
    logic [WIDTH-1:0] tail_next;
    logic             handshake;

    assign out_valid = (count_reg != 2'd0);
    assign out_data  = head_reg;
    assign buf_count = count_reg;
    assign handshake = out_valid && out_ready;

    // arm_reg holds off popping for two edges after reset release, independent of q_fresh.
    assign fifo_pop = arm_reg[1] && q_fresh_reg && !fifo_empty &&
                      ((count_reg < 2'd2) || handshake);

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        case ({fifo_pop, handshake})
            2'b10: begin
                if (count_reg == 2'd0) begin
                    head_next = fifo_q;
                end else begin
                    tail_next = fifo_q;
                end
                count_next = count_reg + 2'd1;
            end
            2'b01: begin
                head_next  = tail_reg;
                count_next = count_reg - 2'd1;
            end
            2'b11: begin
                // Head leaves while a new word arrives; the new word lands behind any survivor.
                if (count_reg == 2'd1) begin
                    head_next = fifo_q;
                end else begin
                    head_next = tail_reg;
                    tail_next = fifo_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_fresh_reg <= 1'b0;
            arm_reg     <= 2'b00;
            count_reg   <= 2'd0;
            head_reg    <= '0;
            tail_reg    <= '0;
        end else begin
            q_fresh_reg <= !fifo_empty && !fifo_pop;
            arm_reg     <= {arm_reg[0], 1'b1};
            count_reg   <= count_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_chk: assert (!(fifo_pop && !handshake && count_reg == 2'd2))
            else begin
                $error("fifo_stream_drain: capture into full skid buffer");
                $finish;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed and random bench for fifo_stream_drain with a behavioural registered-output FIFO
// model upstream and an in-order scoreboard downstream.
module tb_fifo_stream_drain;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_q = 8'h00;
    logic       fifo_pop;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] buf_count;

    fifo_stream_drain #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_q    (fifo_q),
        .fifo_pop  (fifo_pop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .buf_count (buf_count)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         delivered = 0;
    int         pop_cnt = 0;
    int         first_pop = -1;
    int         last_pop = -1;
    logic [7:0] fifo_m[$];
    logic [7:0] exp_q[$];
    logic [7:0] dummy;
    logic       pop_s = 1'b0;
    logic       prev_pop = 1'b0;
    logic       obs_pop = 1'b0;
    logic       obs_valid = 1'b0;
    logic [7:0] obs_data = 8'h00;
    logic [1:0] obs_count = 2'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: FIFO model advances just after the edge, DUT outputs are sampled at the negedge.
    task automatic step(input logic push, input logic [7:0] pdata, input logic rdy);
        @(posedge clk);
        #1;
        if (fifo_m.size() > 0) fifo_q = fifo_m[0];
        if (pop_s && fifo_m.size() > 0) dummy = fifo_m.pop_front();
        if (push) begin
            fifo_m.push_back(pdata);
            exp_q.push_back(pdata);
        end
        fifo_empty = (fifo_m.size() == 0);
        out_ready  = rdy;
        cyc++;
        @(negedge clk);
        obs_pop   = fifo_pop;
        obs_valid = out_valid;
        obs_data  = out_data;
        obs_count = buf_count;
        pop_s     = fifo_pop;
        chk("pop_while_empty", {31'd0, fifo_pop & fifo_empty}, 0);
        chk("pop_back_to_back", {31'd0, fifo_pop & prev_pop}, 0);
        prev_pop = fifo_pop;
        if (fifo_pop) begin
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("stream_order", {24'd0, out_data}, {24'd0, exp_q[0]});
                dummy = exp_q.pop_front();
                delivered++;
                $display("cycle %0d: word 0x%02h delivered (%0d total)", cyc, out_data, delivered);
            end
        end
    endtask

    task automatic clear_stats();
        pop_cnt   = 0;
        first_pop = -1;
        last_pop  = -1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
        chk("drain_complete", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rel;
        int sent;
        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_fifo_pop", {31'd0, fifo_pop}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {24'd0, out_data}, 0);
        chk("rst_buf_count", {30'd0, buf_count}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) step(1'b0, 8'h00, 1'b1);

        // Single word into an empty FIFO
        step(1'b1, 8'h11, 1'b1);
        chk("t1_pop_c1", {31'd0, obs_pop}, 0);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_pop_c2", {31'd0, obs_pop}, 1);
        chk("t1_valid_c2", {31'd0, obs_valid}, 0);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_pop_c3", {31'd0, obs_pop}, 0);
        chk("t1_valid_c3", {31'd0, obs_valid}, 1);
        chk("t1_data_c3", {24'd0, obs_data}, 32'h11);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_count_c4", {30'd0, obs_count}, 0);
        chk("t1_valid_c4", {31'd0, obs_valid}, 0);

        // Eight words, free-running sink: one pop every other cycle
        clear_stats();
        base = delivered;
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1);
        drain(60);
        chk("t2_delivered", delivered - base, 8);
        chk("t2_pops", pop_cnt, 8);
        chk("t2_pop_span", last_pop - first_pop, 14);

        // Four words against a stalled sink
        clear_stats();
        base = delivered;
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (obs_valid) chk("t3_head_hold", {24'd0, obs_data}, 32'h01);
        end
        chk("t3_pops", pop_cnt, 2);
        chk("t3_count", {30'd0, obs_count}, 2);
        chk("t3_data", {24'd0, obs_data}, 32'h01);
        drain(40);
        chk("t3_delivered", delivered - base, 4);

        // Capture and handshake in the same cycle with one word buffered
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        chk("t6_first_pop", {31'd0, obs_pop}, 1);
        step(1'b1, 8'hA3, 1'b0);
        chk("t6_count_one", {30'd0, obs_count}, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("t6_pop_with_hs", {31'd0, obs_pop}, 1);
        chk("t6_valid_with_hs", {31'd0, obs_valid}, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("t6_count_kept", {30'd0, obs_count}, 1);
        chk("t6_next_word", {24'd0, obs_data}, 32'hA2);
        drain(40);

        // Random pushes and random back-pressure
        base = delivered;
        sent = 0;
        for (int i = 0; i < 20000 && (sent < 1000 || exp_q.size() != 0); i++) begin
            if (sent < 1000 && $urandom_range(1) == 1) begin
                step(1'b1, 8'($urandom), 1'($urandom_range(1)));
                sent++;
            end else begin
                step(1'b0, 8'h00, 1'($urandom_range(1)));
            end
        end
        chk("t4_words", delivered - base, 1000);
        chk("t4_leftover", exp_q.size(), 0);

        // Asynchronous reset with a full skid buffer
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h31 + i), 1'b0);
        chk("t5_pre_count", {30'd0, obs_count}, 2);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, out_valid}, 0);
        chk("t5_async_pop", {31'd0, fifo_pop}, 0);
        chk("t5_async_count", {30'd0, buf_count}, 0);
        pop_s = 1'b0;
        exp_q = fifo_m;
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        #3 rst = 1'b1;
        rel = cyc;
        clear_stats();
        for (int i = 0; i < 10 && first_pop < 0; i++) step(1'b0, 8'h00, 1'b1);
        chk("t5_popped_after_release", {31'd0, first_pop >= 0}, 1);
        chk("t5_release_gap", {31'd0, (first_pop - rel) >= 2}, 1);
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
